// File: rtl/rf_sb_if.sv
// rf_sb_if: bundle of the rf_sb write, read, external-I/O and scoreboard signals.
//   N : data width, A : register address width.
//   master modport - the driver side (decode/issue logic or a bench).
//   slave  modport - the register file side.
// Signal names keep the register file's original port names.
interface rf_sb_if #(
  parameter int N = 8,
  parameter int A = 5
);
  logic                wr_en_i;
  logic [A-1:0]        wr_addr_i;
  logic signed [N-1:0] wr_data_i;
  logic [A-1:0]        rs_addr_i;
  logic [A-1:0]        rt_addr_i;
  logic signed [N-1:0] rs_data_o;
  logic signed [N-1:0] rt_data_o;
  logic [N-1:0]        ext_data_i;
  logic                ext_vld_i;
  logic [N-1:0]        ext_data_o;
  logic                ext_upd_o;
  logic                busy_set_i;
  logic [A-1:0]        busy_addr_i;
  logic                rs_busy_o;
  logic                rt_busy_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rs_addr_i, rt_addr_i,
           ext_data_i, ext_vld_i, busy_set_i, busy_addr_i,
    input  rs_data_o, rt_data_o, ext_data_o, ext_upd_o, rs_busy_o, rt_busy_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rs_addr_i, rt_addr_i,
           ext_data_i, ext_vld_i, busy_set_i, busy_addr_i,
    output rs_data_o, rt_data_o, ext_data_o, ext_upd_o, rs_busy_o, rt_busy_o
  );
endinterface

// File: rtl/rf_sb.sv
// rf_sb: 2-read / 1-write register file with busy scoreboard and two
// memory-mapped I/O registers.
//   clk_i - clock, rst_i - synchronous active-high reset.
//   bus   - rf_sb_if.slave:
//     wr_en_i/wr_addr_i/wr_data_i : write port (reg 0 and EXT_IN_IDX ignore writes)
//     rs_addr_i/rs_data_o, rt_addr_i/rt_data_o : combinational read ports
//     ext_data_i/ext_vld_i  : strobed capture into EXT_IN_IDX
//     ext_data_o/ext_upd_o  : registered copy of EXT_OUT_IDX plus write pulse
//     busy_set_i/busy_addr_i: claim a register for an in-flight result
//     rs_busy_o/rt_busy_o   : combinational hazard flags for the read addresses
module rf_sb #(
  parameter int N           = 8,
  parameter int R           = 32,
  parameter int EXT_IN_IDX  = 30,
  parameter int EXT_OUT_IDX = 31,
  parameter int BYPASS      = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  rf_sb_if.slave   bus
);
  localparam int A = $clog2(R);
  localparam logic [A-1:0] IN_ADDR  = A'(EXT_IN_IDX);
  localparam logic [A-1:0] OUT_ADDR = A'(EXT_OUT_IDX);

  logic signed [N-1:0] regs_q [R];
  logic [R-1:0]        busy_q, busy_d;
  logic [N-1:0]        ext_data_q;
  logic                ext_upd_q;

  logic wr_ok;
  logic rs_fwd, rt_fwd;
  logic set_ok;

  // Register 0 and the external-input register are never architectural
  // write targets; everything downstream keys off this qualified enable.
  assign wr_ok  = bus.wr_en_i && (bus.wr_addr_i != '0) && (bus.wr_addr_i != IN_ADDR);
  assign set_ok = bus.busy_set_i && (bus.busy_addr_i != '0) && (bus.busy_addr_i != IN_ADDR);
  assign rs_fwd = (BYPASS != 0) && wr_ok && (bus.wr_addr_i == bus.rs_addr_i);
  assign rt_fwd = (BYPASS != 0) && wr_ok && (bus.wr_addr_i == bus.rt_addr_i);

  // Clear on write first, then set, so a same-cycle claim by a newly issued
  // producer survives the completing write.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[bus.wr_addr_i]   = 1'b0;
    if (set_ok) busy_d[bus.busy_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < R; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      ext_data_q <= '0;
      ext_upd_q  <= 1'b0;
    end else begin
      if (wr_ok) regs_q[bus.wr_addr_i] <= bus.wr_data_i;
      if (bus.ext_vld_i) regs_q[EXT_IN_IDX] <= bus.ext_data_i;
      busy_q    <= busy_d;
      ext_upd_q <= wr_ok && (bus.wr_addr_i == OUT_ADDR);
      if (wr_ok && (bus.wr_addr_i == OUT_ADDR)) ext_data_q <= bus.wr_data_i;
    end
  end

  always_comb begin
    bus.rs_data_o = regs_q[bus.rs_addr_i];
    bus.rt_data_o = regs_q[bus.rt_addr_i];
    if (rs_fwd) bus.rs_data_o = bus.wr_data_i;
    if (rt_fwd) bus.rt_data_o = bus.wr_data_i;
    if (bus.rs_addr_i == '0) bus.rs_data_o = '0;
    if (bus.rt_addr_i == '0) bus.rt_data_o = '0;
  end

  // A forwarding write delivers the value now, so the hazard is already resolved.
  assign bus.rs_busy_o  = busy_q[bus.rs_addr_i] && !rs_fwd;
  assign bus.rt_busy_o  = busy_q[bus.rt_addr_i] && !rt_fwd;
  assign bus.ext_data_o = ext_data_q;
  assign bus.ext_upd_o  = ext_upd_q;
endmodule

// File: tb/tb_rf_sb.sv
module tb_rf_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  rf_sb_if #(.N(8),  .A(5)) b0 ();
  rf_sb_if #(.N(8),  .A(5)) b1 ();
  rf_sb_if #(.N(16), .A(6)) b2 ();

  rf_sb #(.N(8), .R(32), .EXT_IN_IDX(30), .EXT_OUT_IDX(31), .BYPASS(1))
    u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  rf_sb #(.N(8), .R(32), .EXT_IN_IDX(30), .EXT_OUT_IDX(31), .BYPASS(0))
    u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  rf_sb #(.N(16), .R(64), .EXT_IN_IDX(62), .EXT_OUT_IDX(63), .BYPASS(1))
    u2 (.clk_i(clk), .rst_i(rst), .bus(b2));

  // Shared stimulus for the two 8-bit instances (they differ only in BYPASS).
  logic       wr_en, ext_v, bset;
  logic [4:0] wr_addr, rs, rt, baddr;
  logic [7:0] wr_data, ext_d;

  always_comb begin
    b0.wr_en_i = wr_en;  b0.wr_addr_i = wr_addr; b0.wr_data_i = wr_data;
    b0.rs_addr_i = rs;   b0.rt_addr_i = rt;      b0.ext_data_i = ext_d;
    b0.ext_vld_i = ext_v; b0.busy_set_i = bset;  b0.busy_addr_i = baddr;
    b1.wr_en_i = wr_en;  b1.wr_addr_i = wr_addr; b1.wr_data_i = wr_data;
    b1.rs_addr_i = rs;   b1.rt_addr_i = rt;      b1.ext_data_i = ext_d;
    b1.ext_vld_i = ext_v; b1.busy_set_i = bset;  b1.busy_addr_i = baddr;
  end

  // Reference model: architectural register contents and pending flags.
  logic [7:0] mem [32];
  bit         busy [32];
  logic [7:0] m_ext;
  logic       m_upd;

  function automatic bit accepted();
    return wr_en && (wr_addr != 5'd0) && (wr_addr != 5'd30);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 8'h00;
    if (byp && accepted() && (wr_addr == a)) return wr_data;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    return busy[a] && !(byp && accepted() && (wr_addr == a));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    acc = accepted();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mem[i] = 8'h00; busy[i] = 1'b0; end
      m_ext = 8'h00;
      m_upd = 1'b0;
    end else begin
      m_upd = acc && (wr_addr == 5'd31);
      if (m_upd) m_ext = wr_data;
      if (acc) begin mem[wr_addr] = wr_data; busy[wr_addr] = 1'b0; end
      if (ext_v) mem[30] = ext_d;
      if (bset && (baddr != 5'd0) && (baddr != 5'd30)) busy[baddr] = 1'b1;
    end
  endtask

  // Inputs are already applied; check combinational outputs, clock, check registered outputs.
  task automatic cycle();
    #1;
    chk("u0_rs_data", b0.rs_data_o, exp_rd(rs, 1'b1));
    chk("u0_rt_data", b0.rt_data_o, exp_rd(rt, 1'b1));
    chk("u0_rs_busy", {7'd0, b0.rs_busy_o}, {7'd0, exp_busy(rs, 1'b1)});
    chk("u0_rt_busy", {7'd0, b0.rt_busy_o}, {7'd0, exp_busy(rt, 1'b1)});
    chk("u1_rs_data", b1.rs_data_o, exp_rd(rs, 1'b0));
    chk("u1_rt_data", b1.rt_data_o, exp_rd(rt, 1'b0));
    chk("u1_rs_busy", {7'd0, b1.rs_busy_o}, {7'd0, exp_busy(rs, 1'b0)});
    chk("u1_rt_busy", {7'd0, b1.rt_busy_o}, {7'd0, exp_busy(rt, 1'b0)});
    @(posedge clk);
    model_edge();
    #1;
    chk("u0_ext_data", b0.ext_data_o, m_ext);
    chk("u0_ext_upd", {7'd0, b0.ext_upd_o}, {7'd0, m_upd});
    chk("u1_ext_data", b1.ext_data_o, m_ext);
    chk("u1_ext_upd", {7'd0, b1.ext_upd_o}, {7'd0, m_upd});
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rs = '0; rt = '0;
    ext_d = '0; ext_v = 1'b0; bset = 1'b0; baddr = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    idle();
    b2.wr_en_i = 1'b0; b2.wr_addr_i = '0; b2.wr_data_i = '0;
    b2.rs_addr_i = '0; b2.rt_addr_i = '0; b2.ext_data_i = '0;
    b2.ext_vld_i = 1'b0; b2.busy_set_i = 1'b0; b2.busy_addr_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_edge();
    #1 rst = 1'b0;

    // Reset clears data, busy and ext-out even after activity.
    idle(); wr(5'd5, 8'h55); bset = 1'b1; baddr = 5'd5; cycle();
    idle(); rst = 1'b1; rs = 5'd5; cycle();
    rst = 1'b0; idle(); rs = 5'd5; cycle();

    // Register 0 and external-input register protection / capture.
    idle(); wr(5'd0, 8'h7F); cycle();
    idle(); wr(5'd30, 8'h7F); rs = 5'd30; rt = 5'd0; cycle();
    idle(); rs = 5'd0; rt = 5'd30; cycle();
    idle(); ext_v = 1'b1; ext_d = 8'hA3; rt = 5'd30; cycle();
    idle(); ext_v = 1'b0; ext_d = 8'h11; rt = 5'd30; cycle();
    idle(); rt = 5'd30; cycle();

    // Same-cycle forwarding to both ports, then stored value.
    idle(); wr(5'd7, 8'h3C); rs = 5'd7; rt = 5'd7; cycle();
    idle(); rs = 5'd7; rt = 5'd7; cycle();

    // Back-to-back identical writes to the ext-out register.
    idle(); wr(5'd31, 8'h9A); cycle();
    idle(); wr(5'd31, 8'h9A); cycle();
    idle(); rs = 5'd31; cycle();
    idle(); cycle();

    // Scoreboard set, forwarded clear, and set-wins collision.
    idle(); bset = 1'b1; baddr = 5'd4; cycle();
    idle(); rs = 5'd4; cycle();
    idle(); wr(5'd4, 8'h12); rs = 5'd4; cycle();
    idle(); rs = 5'd4; cycle();
    idle(); wr(5'd4, 8'h21); bset = 1'b1; baddr = 5'd4; cycle();
    idle(); rs = 5'd4; rt = 5'd4; cycle();
    idle(); bset = 1'b1; baddr = 5'd0; cycle();
    idle(); rs = 5'd0; bset = 1'b1; baddr = 5'd30; cycle();
    idle(); rs = 5'd0; rt = 5'd30; cycle();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = 8'($urandom);
      rs      = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rt      = 5'($urandom_range(0, 31));
      ext_v   = ($urandom_range(0, 3) == 0);
      ext_d   = 8'($urandom);
      bset    = ($urandom_range(0, 2) == 0);
      baddr   = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rst     = ($urandom_range(0, 63) == 0);
      cycle();
      rst = 1'b0;
    end
    idle();

    // 16-bit / 64-entry build: sign and relocated I/O indices.
    b2.wr_en_i = 1'b1; b2.wr_addr_i = 6'd63; b2.wr_data_i = 16'sh8000; b2.rs_addr_i = 6'd63;
    #1;
    n_cmp++;
    assert (int'(b2.rs_data_o) === -32768) else begin
      n_err++;
      $error("FAIL w_fwd_signed observed=%0d expected=%0d", int'(b2.rs_data_o), -32768);
    end
    @(posedge clk); #1;
    b2.wr_en_i = 1'b0;
    #1;
    n_cmp++;
    assert (int'(b2.rs_data_o) === -32768) else begin
      n_err++;
      $error("FAIL w_stored_signed observed=%0d expected=%0d", int'(b2.rs_data_o), -32768);
    end
    chkw("w_ext_data", b2.ext_data_o, 16'h8000);
    chkw("w_ext_upd", {15'd0, b2.ext_upd_o}, 16'd1);
    b2.ext_vld_i = 1'b1; b2.ext_data_i = 16'h1234;
    b2.wr_en_i = 1'b1; b2.wr_addr_i = 6'd62; b2.wr_data_i = 16'sh7777; b2.rt_addr_i = 6'd62;
    #1;
    chkw("w_in_nofwd", b2.rt_data_o, 16'h0000);
    @(posedge clk); #1;
    b2.ext_vld_i = 1'b0; b2.wr_en_i = 1'b0;
    #1;
    chkw("w_in_capture", b2.rt_data_o, 16'h1234);
    chkw("w_ext_upd_low", {15'd0, b2.ext_upd_o}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
